vga_fb_arbiter: RTL

//  Shares one single-port 16-bit pixel RAM (2 pixels/word, RGB332) between VGA scan-out and one pixel writer.

---
 rtl/vga_fb_arbiter_if.sv | 27 ++
 rtl/vga_fb_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Writer handshake plus single-port pixel RAM bus; the arbiter uses the slave view,
// while the writer and RAM side use the master view.
interface vga_fb_arbiter_if #(
  parameter int PA_W = 19,
  parameter int MA_W = 18
);
  logic            wr_valid;
  logic            wr_ready;
  logic [PA_W-1:0] wr_addr;
  logic [7:0]      wr_data;
  logic            wr_drop;
  logic            mem_en;
  logic [1:0]      mem_we;
  logic [MA_W-1:0] mem_addr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, wr_drop, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, wr_drop, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Time-slices one pixel RAM between scan-out (even active slots) and a single writer; colour and syncs lag the inputs by 3 clk.
// The writer stalls through wr_ready while its one-entry holding register waits for the next non-read slot.
module vga_fb_arbiter #(
  parameter int HBP   = 144,
  parameter int VBP   = 31,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int PA_W  = 19,
  parameter int MA_W  = 18
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [9:0]      hc,
  input  logic [9:0]      vc,
  input  logic            vidon,
  input  logic            hsync,
  input  logic            vsync,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic [2:0]      red,
  output logic [2:0]      green,
  output logic [1:0]      blue,
  vga_fb_arbiter_if.slave bus
);
  localparam logic [9:0]      HBP_V = 10'(HBP);
  localparam logic [9:0]      VBP_V = 10'(VBP);
  localparam logic [PA_W-1:0] NPIX  = PA_W'(H_ACT * V_ACT);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  state_t          state, state_nxt;
  logic            frame_start, run_px, rd_slot, commit, accept, in_range;
  logic [MA_W-1:0] rptr, rd_addr;
  logic            hold_full;
  logic [PA_W-1:0] hold_addr;
  logic [7:0]      hold_data;
  logic [2:0]      hs_d, vs_d;
  logic [1:0]      act_d, rd_d;
  logic [15:0]     word;
  logic [7:0]      pix;

  assign frame_start = (hc == HBP_V) && (vc == VBP_V);
  // The frame-start cycle already counts as running so its read slot is not lost.
  assign run_px      = vidon && ((state == RUN) || frame_start);
  assign in_range    = hold_addr < NPIX;
  assign accept      = bus.wr_valid && !hold_full && !clr;

  assign bus.wr_ready  = !hold_full;
  assign bus.mem_wdata = {hold_data, hold_data};

  always_comb begin
    state_nxt    = state;
    rd_addr      = rptr;
    rd_slot      = 1'b0;
    commit       = 1'b0;
    bus.mem_en   = 1'b0;
    bus.mem_we   = 2'b00;
    bus.mem_addr = '0;
    bus.wr_drop  = 1'b0;
    if (frame_start) begin
      state_nxt = RUN;
      rd_addr   = '0;
    end
    rd_slot = !clr && run_px && (hc[0] == HBP_V[0]);
    commit  = !clr && hold_full && !rd_slot;
    if (rd_slot) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = rd_addr;
    end else if (commit) begin
      if (in_range) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = hold_addr[0] ? 2'b10 : 2'b01;
        bus.mem_addr = MA_W'(hold_addr >> 1);
      end else begin
        bus.wr_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= WAIT_FRAME;
      rptr      <= '0;
      hold_full <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_slot)
        rptr <= rd_addr + MA_W'(1);
      if (accept)
        hold_full <= 1'b1;
      else if (commit)
        hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_addr <= bus.wr_addr;
      hold_data <= bus.wr_data;
    end
  end

  // One fetched word feeds two consecutive pixels: low byte at +3, high byte at +4.
  always_ff @(posedge clk) begin
    if (clr) begin
      hs_d  <= '1;
      vs_d  <= '1;
      act_d <= '0;
      rd_d  <= '0;
      word  <= '0;
      pix   <= '0;
    end else begin
      hs_d  <= {hs_d[1:0], hsync};
      vs_d  <= {vs_d[1:0], vsync};
      act_d <= {act_d[0], run_px};
      rd_d  <= {rd_d[0], rd_slot};
      if (rd_d[0])
        word <= bus.mem_rdata;
      pix <= !act_d[1] ? 8'h00 : (rd_d[1] ? word[7:0] : word[15:8]);
    end
  end

  assign hsync_o            = hs_d[2];
  assign vsync_o            = vs_d[2];
  assign {red, green, blue} = pix;
endmodule
